// File: rtl/qspi_seq_pkg.sv
// Shared types and constants for the QSPI command sequencer.
package qspi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CFG0      = 3'd1,
        CFG1      = 3'd2,
        START     = 3'd3,
        XFER      = 3'd4,
        WAIT_DONE = 3'd5
    } seq_state_t;

    // Controller config register select values
    localparam logic CFG_ADDR_INSTR = 1'b0;
    localparam logic CFG_ADDR_ADDR  = 1'b1;

    // Width of the optional transfer watchdog
    localparam int unsigned WDOG_BITS = 16;

endpackage

// File: rtl/qspi_seq_fifo.sv
// Read-data FIFO: synchronous, power-of-two depth, flushed by active-low async reset.
module qspi_seq_fifo #(
    parameter int unsigned DATA_BITS  = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_push,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_pop,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;
    logic                 w_push;
    logic                 w_pop;

    assign o_full  = (r_count == DEPTH_L);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    // Head is forced to zero while empty so the output is clean after reset
    assign o_data  = o_empty ? '0 : r_mem[r_rptr];

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop keeps count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/qspi_cmd_sequencer.sv
// Host command front-end for top_qspi_controller: writes both config
// registers, pulses start, then streams tx words or buffers rx words.
// Optional build macro QSPI_SEQ_TIMEOUT_EN enables a 16-bit transfer watchdog.
module qspi_cmd_sequencer
    import qspi_seq_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned SHIFT_REG_BITS = 32,
    parameter int unsigned DIVIDER_WIDTH  = 8,
    parameter int unsigned NSLAVE         = 4,
    parameter int unsigned LEN_BITS       = 5,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rw,
    input  logic [SHIFT_REG_BITS-1:0] cmd_cfg,
    input  logic [SHIFT_REG_BITS-1:0] cmd_addr,
    input  logic [LEN_BITS-1:0]       cmd_len,
    input  logic [$clog2(NSLAVE)-1:0] cmd_cs,
    input  logic [DIVIDER_WIDTH-1:0]  cmd_dvsr,
    input  logic                      cmd_cpol,
    input  logic                      cmd_cpha,
    output logic                      cmd_done,
    output logic                      cmd_err,
    input  logic [DATA_BITS-1:0]      wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic [DATA_BITS-1:0]      rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      config_write,
    output logic                      config_addr,
    output logic [SHIFT_REG_BITS-1:0] config_data,
    output logic                      start,
    output logic                      cpol,
    output logic                      cpha,
    output logic [DIVIDER_WIDTH-1:0]  dvsr,
    output logic [$clog2(NSLAVE)-1:0] cs_num,
    output logic [DATA_BITS-1:0]      tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [DATA_BITS-1:0]      rx_data,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic                      busy,
    input  logic                      done
);

    localparam int unsigned CS_W = $clog2(NSLAVE);

    seq_state_t                r_state;
    seq_state_t                w_next;
    logic                      r_rw;
    logic [SHIFT_REG_BITS-1:0] r_cfg;
    logic [SHIFT_REG_BITS-1:0] r_addr;
    logic [LEN_BITS-1:0]       r_len;
    logic [CS_W-1:0]           r_cs;
    logic [DIVIDER_WIDTH-1:0]  r_dvsr;
    logic                      r_cpol;
    logic                      r_cpha;
    logic [LEN_BITS-1:0]       r_word_cnt;
    logic                      r_cmd_done;
    logic                      r_cmd_err;

    logic w_cmd_hs;
    logic w_tx_hs;
    logic w_rx_hs;
    logic w_xfer_hs;
    logic w_last;
    logic w_fin;
    logic w_fin_err;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_unused;

    // The controller busy flag carries no information the done pulse lacks
    assign w_unused = busy;

    assign w_cmd_hs  = cmd_valid && (r_state == IDLE);
    assign w_tx_hs   = (r_state == XFER) && !r_rw && wr_valid && tx_ready;
    assign w_rx_hs   = (r_state == XFER) && r_rw && data_valid && !w_fifo_full;
    assign w_xfer_hs = w_tx_hs || w_rx_hs;
    assign w_last    = w_xfer_hs && ((r_word_cnt + 1'b1) == r_len);

    assign cmd_done = r_cmd_done;
    assign cmd_err  = r_cmd_err;
    assign cpol     = r_cpol;
    assign cpha     = r_cpha;
    assign dvsr     = r_dvsr;
    assign cs_num   = r_cs;
    assign rd_valid = !w_fifo_empty;

`ifdef QSPI_SEQ_TIMEOUT_EN
    logic [WDOG_BITS-1:0] r_wdog;
    logic                 w_wdog_expire;

    assign w_wdog_expire = ((r_state == XFER) || (r_state == WAIT_DONE)) && (r_wdog == '1);

    // Watchdog: restarts on state entry and on every data handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if ((w_next != r_state) || w_xfer_hs) begin
            r_wdog <= '0;
        end else if ((r_state == XFER) || (r_state == WAIT_DONE)) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and completion decode
    always_comb begin
        w_next    = r_state;
        w_fin     = 1'b0;
        w_fin_err = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cmd_hs) begin
                    if ((cmd_len == '0) || (cmd_rw && !w_fifo_empty)) begin
                        w_fin     = 1'b1;
                        w_fin_err = 1'b1;
                    end else begin
                        w_next = CFG0;
                    end
                end
            end
            CFG0:  w_next = CFG1;
            CFG1:  w_next = START;
            START: w_next = XFER;
            XFER: begin
                // done with the final handshake in the same cycle is a clean finish
                if (done) begin
                    w_next    = IDLE;
                    w_fin     = 1'b1;
                    w_fin_err = !w_last;
                end else if (w_last) begin
                    w_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    w_next = IDLE;
                    w_fin  = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
`ifdef QSPI_SEQ_TIMEOUT_EN
        if (w_wdog_expire && !w_fin) begin
            w_next    = IDLE;
            w_fin     = 1'b1;
            w_fin_err = 1'b1;
        end
`endif
    end

    // Controller and host handshake outputs decoded from state
    always_comb begin
        cmd_ready    = (r_state == IDLE);
        config_write = (r_state == CFG0) || (r_state == CFG1);
        config_addr  = (r_state == CFG1) ? CFG_ADDR_ADDR : CFG_ADDR_INSTR;
        config_data  = '0;
        if (r_state == CFG0) config_data = r_cfg;
        if (r_state == CFG1) config_data = r_addr;
        start        = (r_state == START);
        tx_data      = '0;
        tx_valid     = 1'b0;
        wr_ready     = 1'b0;
        data_ready   = 1'b0;
        if (r_state == XFER) begin
            if (r_rw) begin
                data_ready = !w_fifo_full;
            end else begin
                tx_data  = wr_data;
                tx_valid = wr_valid;
                wr_ready = tx_ready;
            end
        end
    end

    // Command latch, word counter and completion pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rw       <= 1'b0;
            r_cfg      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_cs       <= '0;
            r_dvsr     <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_word_cnt <= '0;
            r_cmd_done <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_done <= w_fin;
            r_cmd_err  <= w_fin && w_fin_err;
            if (w_cmd_hs) begin
                r_rw       <= cmd_rw;
                r_cfg      <= cmd_cfg;
                r_addr     <= cmd_addr;
                r_len      <= cmd_len;
                r_cs       <= cmd_cs;
                r_dvsr     <= cmd_dvsr;
                r_cpol     <= cmd_cpol;
                r_cpha     <= cmd_cpha;
                r_word_cnt <= '0;
            end else if (w_xfer_hs) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    qspi_seq_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_hs),
        .i_data  (rx_data),
        .i_pop   (rd_ready),
        .o_data  (rd_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_qspi_cmd_sequencer.sv
// Scoreboard bench for qspi_cmd_sequencer: stimulus pushes expectations,
// a negedge monitor pops and compares whenever the DUT presents an event.
module tb_qspi_cmd_sequencer;

    localparam int unsigned DATA_BITS      = 32;
    localparam int unsigned SHIFT_REG_BITS = 32;
    localparam int unsigned DIVIDER_WIDTH  = 8;
    localparam int unsigned NSLAVE         = 4;
    localparam int unsigned LEN_BITS       = 5;
    localparam int unsigned FIFO_DEPTH     = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
    logic [31:0] cmd_cfg = '0, cmd_addr = '0;
    logic [4:0]  cmd_len = '0;
    logic [1:0]  cmd_cs = '0;
    logic [7:0]  cmd_dvsr = '0;
    logic        cmd_cpol = 1'b0, cmd_cpha = 1'b0;
    logic        cmd_done, cmd_err;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready = 1'b0;
    logic        config_write, config_addr;
    logic [31:0] config_data;
    logic        start, cpol, cpha;
    logic [7:0]  dvsr;
    logic [1:0]  cs_num;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready = 1'b0;
    logic [31:0] rx_data = '0;
    logic        data_valid = 1'b0, data_ready;
    logic        busy = 1'b0, done = 1'b0;

    typedef struct {
        logic err;
        int   lat;
    } done_exp_t;

    logic [32:0] q_cfg[$];
    logic [31:0] q_tx[$];
    logic [31:0] q_rd[$];
    done_exp_t   q_done[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, hs_cyc = 0, cfg0_cyc = 0;
    int n_cfg_ev = 0, n_start_ev = 0, n_done_ev = 0, n_pop = 0;

    qspi_cmd_sequencer #(
        .DATA_BITS      (DATA_BITS),
        .SHIFT_REG_BITS (SHIFT_REG_BITS),
        .DIVIDER_WIDTH  (DIVIDER_WIDTH),
        .NSLAVE         (NSLAVE),
        .LEN_BITS       (LEN_BITS),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .clk (clk), .reset (reset),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_rw (cmd_rw),
        .cmd_cfg (cmd_cfg), .cmd_addr (cmd_addr), .cmd_len (cmd_len),
        .cmd_cs (cmd_cs), .cmd_dvsr (cmd_dvsr), .cmd_cpol (cmd_cpol), .cmd_cpha (cmd_cpha),
        .cmd_done (cmd_done), .cmd_err (cmd_err),
        .wr_data (wr_data), .wr_valid (wr_valid), .wr_ready (wr_ready),
        .rd_data (rd_data), .rd_valid (rd_valid), .rd_ready (rd_ready),
        .config_write (config_write), .config_addr (config_addr), .config_data (config_data),
        .start (start), .cpol (cpol), .cpha (cpha), .dvsr (dvsr), .cs_num (cs_num),
        .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready),
        .rx_data (rx_data), .data_valid (data_valid), .data_ready (data_ready),
        .busy (busy), .done (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_ev(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event/timeout expected none (cycle %0d)", name, cyc);
    endfunction

    // Monitor: every DUT-presented event is matched against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (cmd_valid && cmd_ready) hs_cyc = cyc;
            if (config_write) begin
                n_cfg_ev++;
                if (config_addr == 1'b0) cfg0_cyc = cyc;
                else chk("cfg1_after_cfg0", 64'(cyc - cfg0_cyc), 64'd1);
                if (q_cfg.size() == 0) fail_ev("cfg_unexpected");
                else chk("cfg_word", {31'd0, config_addr, config_data}, {31'd0, q_cfg.pop_front()});
            end
            if (start) begin
                n_start_ev++;
                chk("start_latency", 64'(cyc - hs_cyc), 64'd3);
            end
            if (tx_valid && tx_ready) begin
                if (q_tx.size() == 0) fail_ev("tx_unexpected");
                else chk("tx_data", 64'(tx_data), 64'(q_tx.pop_front()));
            end
            if (rd_valid && rd_ready) begin
                n_pop++;
                if (q_rd.size() == 0) fail_ev("rd_unexpected");
                else chk("rd_data", 64'(rd_data), 64'(q_rd.pop_front()));
            end
            if (cmd_done) begin
                done_exp_t e;
                n_done_ev++;
                if (q_done.size() == 0) fail_ev("cmd_done_unexpected");
                else begin
                    e = q_done.pop_front();
                    chk("cmd_err", 64'(cmd_err), 64'(e.err));
                    if (e.lat >= 0) chk("cmd_done_latency", 64'(cyc - hs_cyc), 64'(e.lat));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, 64'({cmd_ready, cmd_done, cmd_err, wr_ready, rd_valid, config_write,
                                 config_addr, start, cpol, cpha, tx_valid, data_ready}), 64'h800);
        chk({tag, "_data"}, 64'(rd_data | config_data | tx_data), 64'd0);
        chk({tag, "_fields"}, 64'({dvsr, cs_num}), 64'd0);
    endtask

    task automatic issue(input logic rw, input logic [31:0] cfg, input logic [31:0] addr,
                         input logic [4:0] len, input logic [1:0] cs, input logic [7:0] dv,
                         input logic pol, input logic pha);
        logic acc;
        int   b;
        cmd_rw = rw; cmd_cfg = cfg; cmd_addr = addr; cmd_len = len;
        cmd_cs = cs; cmd_dvsr = dv; cmd_cpol = pol; cmd_cpha = pha;
        cmd_valid = 1'b1;
        b = 0;
        do begin
            @(negedge clk);
            acc = cmd_ready;
            tick();
            b++;
        end while (!acc && b < 20);
        if (!acc) fail_ev("cmd_accept_timeout");
        cmd_valid = 1'b0;
        // scramble fields so the latched copies are what gets observed
        cmd_cfg = ~cfg; cmd_addr = ~addr; cmd_cs = ~cs; cmd_dvsr = ~dv;
        cmd_cpol = ~pol; cmd_cpha = ~pha; cmd_len = 5'd0;
    endtask

    task automatic tx_send(input int n, input logic [31:0] base);
        logic h;
        int   b;
        for (int i = 0; i < n; i++) begin
            wr_data  = base + 32'(i);
            wr_valid = 1'b1;
            q_tx.push_back(base + 32'(i));
            b = 0;
            do begin
                @(negedge clk);
                h = wr_valid && wr_ready;
                tick();
                b++;
            end while (!h && b < 100);
            if (!h) begin
                fail_ev("tx_handshake_timeout");
                break;
            end
        end
        wr_valid = 1'b0;
        wr_data  = '0;
    endtask

    task automatic rx_send(input int n, input logic [31:0] base);
        logic h;
        int   b;
        for (int i = 0; i < n; i++) begin
            rx_data    = base + 32'(i);
            data_valid = 1'b1;
            b = 0;
            do begin
                @(negedge clk);
                h = data_valid && data_ready;
                if (h) q_rd.push_back(base + 32'(i));
                tick();
                b++;
            end while (!h && b < 100);
            if (!h) begin
                fail_ev("rx_handshake_timeout");
                break;
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic wait_cmd_done(input int bound);
        int s;
        int b;
        s = n_done_ev;
        b = 0;
        while (n_done_ev == s && b < bound) begin
            tick();
            b++;
        end
        if (n_done_ev == s) fail_ev("cmd_done_timeout");
    endtask

    task automatic drain(input int bound);
        int b;
        rd_ready = 1'b1;
        b = 0;
        while (rd_valid && b < bound) begin
            tick();
            b++;
        end
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cfg_before, start_before, pop_before, done_before;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b1;
        tick();
        tx_ready = 1'b1;

        // Write, len=3
        q_cfg.push_back({1'b0, 32'h0000_3802});
        q_cfg.push_back({1'b1, 32'h0012_3400});
        q_done.push_back('{err: 1'b0, lat: -1});
        issue(1'b0, 32'h0000_3802, 32'h0012_3400, 5'd3, 2'd2, 8'h04, 1'b1, 1'b0);
        tx_send(3, 32'hC0DE_0000);
        @(negedge clk);
        chk("latched_fields", 64'({cpol, cpha, dvsr, cs_num}), 64'({1'b1, 1'b0, 8'h04, 2'd2}));
        chk("wait_done_wr_ready", 64'(wr_ready), 64'd0);
        tick();
        pulse_done();
        wait_cmd_done(20);
        chk("w1_start_count", 64'(n_start_ev), 64'd1);
        chk("w1_cfg_count", 64'(n_cfg_ev), 64'd2);

        // Read, len=10, FIFO fills with rd_ready low
        q_cfg.push_back({1'b0, 32'h0000_6B01});
        q_cfg.push_back({1'b1, 32'h00AB_CD00});
        q_done.push_back('{err: 1'b0, lat: -1});
        pop_before = n_pop;
        issue(1'b1, 32'h0000_6B01, 32'h00AB_CD00, 5'd10, 2'd1, 8'h02, 1'b0, 1'b1);
        rx_send(8, 32'hA000_0000);
        rx_data    = 32'hA000_0008;
        data_valid = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("full_data_ready", 64'(data_ready), 64'd0);
        chk("full_rd_valid", 64'(rd_valid), 64'd1);
        tick();
        rd_ready = 1'b1;
        rx_send(2, 32'hA000_0008);
        pulse_done();
        wait_cmd_done(20);
        drain(40);
        chk("r10_pop_count", 64'(n_pop - pop_before), 64'd10);

        // len=0 rejected without touching the controller
        cfg_before   = n_cfg_ev;
        start_before = n_start_ev;
        q_done.push_back('{err: 1'b1, lat: 1});
        issue(1'b0, 32'h1111_1111, 32'h2222_2222, 5'd0, 2'd3, 8'h10, 1'b0, 1'b0);
        wait_cmd_done(10);
        repeat (3) tick();
        chk("len0_no_cfg", 64'(n_cfg_ev - cfg_before), 64'd0);
        chk("len0_no_start", 64'(n_start_ev - start_before), 64'd0);

        // Read len=4 cut short by done after 2 words
        q_cfg.push_back({1'b0, 32'h0000_0B03});
        q_cfg.push_back({1'b1, 32'h0000_1000});
        q_done.push_back('{err: 1'b1, lat: -1});
        pop_before = n_pop;
        issue(1'b1, 32'h0000_0B03, 32'h0000_1000, 5'd4, 2'd0, 8'h08, 1'b1, 1'b1);
        rx_send(2, 32'hB000_0000);
        repeat (2) tick();
        pulse_done();
        wait_cmd_done(10);
        @(negedge clk);
        chk("short_rd_valid", 64'(rd_valid), 64'd1);
        tick();

        // Read with residual FIFO data is refused
        start_before = n_start_ev;
        q_done.push_back('{err: 1'b1, lat: 1});
        issue(1'b1, 32'h0000_0B03, 32'h0000_2000, 5'd1, 2'd0, 8'h08, 1'b0, 1'b0);
        wait_cmd_done(10);
        chk("busy_fifo_no_start", 64'(n_start_ev - start_before), 64'd0);
        drain(20);
        chk("short_pop_count", 64'(n_pop - pop_before), 64'd2);

        // Reset during XFER of a write, len=5
        q_cfg.push_back({1'b0, 32'h0000_3203});
        q_cfg.push_back({1'b1, 32'h0055_0000});
        issue(1'b0, 32'h0000_3203, 32'h0055_0000, 5'd5, 2'd3, 8'h20, 1'b1, 1'b1);
        tx_send(2, 32'hD000_0000);
        @(negedge clk);
        chk("xfer_wr_ready", 64'(wr_ready), 64'd1);
        done_before = n_done_ev;
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        reset    = 1'b0;
        #1;
        check_reset_outputs("midreset");
        wr_valid = 1'b0;
        wr_data  = '0;
        tick();
        tick();
        reset = 1'b1;
        repeat (5) tick();
        chk("midreset_no_done", 64'(n_done_ev - done_before), 64'd0);

`ifdef QSPI_SEQ_TIMEOUT_EN
        // Watchdog fires when the controller never takes a word
        tx_ready = 1'b0;
        q_cfg.push_back({1'b0, 32'h0000_0002});
        q_cfg.push_back({1'b1, 32'h0000_0004});
        q_done.push_back('{err: 1'b1, lat: -1});
        issue(1'b0, 32'h0000_0002, 32'h0000_0004, 5'd2, 2'd1, 8'h01, 1'b0, 1'b0);
        wait_cmd_done(70000);
        tx_ready = 1'b1;
        tick();
`endif

        chk("leftover_expectations", 64'(q_cfg.size() + q_tx.size() + q_rd.size() + q_done.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
